volatility_sched: RTL and testbench
===================================

# volatility_sched

Round-robin scheduler that shares one `volatility_mem` datapath between `NUM_STOCKS` market-data requesters. It accepts best bid/ask updates per stock and computes each stock's circular-buffer write address. It issues one write to the datapath at a time and captures the resulting volatility and current price. The result goes to the quoting logic through a valid/ready output. It also owns the datapath's buffer-size reciprocal configuration register.

## Interface
- `FP_WORD_SIZE`, 64: volatility / reciprocal width (Q32.32)
- `DATA_WIDTH`, 32: price width
- `BUFFER_SIZE`, 32: samples per stock; power of two
- `NUM_STOCKS`, 4: requesters; power of two
- Reset is `i_reset_n`, synchronous, active-low. The clock is `i_clk`.
- `i_clk` in 1: clock
- `i_reset_n` in 1: synchronous active-low reset
- `i_req_valid` in NUM_STOCKS: per-stock update request
- `i_req_ask` in NUM_STOCKS*DATA_WIDTH: packed best ask; stock k at [k*DATA_WIDTH +: DATA_WIDTH]
- `i_req_bid` in NUM_STOCKS*DATA_WIDTH: packed best bid, same packing
- `o_req_ready` out NUM_STOCKS: one-hot grant; the request is accepted when valid&ready
- `i_cfg_recip_wr` in 1: load reciprocal
- `i_cfg_recip` in FP_WORD_SIZE: new reciprocal value
- `o_dp_valid` out 1: datapath write strobe
- `o_dp_write_address` out $clog2(NUM_STOCKS*BUFFER_SIZE): datapath address
- `o_dp_stock_id` out $clog2(NUM_STOCKS): datapath stock id
- `o_dp_best_ask`, `o_dp_best_bid` out DATA_WIDTH: datapath prices
- `o_dp_recip` out FP_WORD_SIZE: datapath buffer-size reciprocal
- `i_dp_volatility` in FP_WORD_SIZE: datapath volatility
- `i_dp_curr_price` in DATA_WIDTH: datapath current price
- `i_dp_buffer_full` in 1: datapath buffer full
- `i_dp_data_valid` in 1: datapath data valid
- `o_res_valid` out 1, `i_res_ready` in 1: result handshake
- `o_res_stock_id` out $clog2(NUM_STOCKS): result stock id
- `o_res_volatility` out FP_WORD_SIZE: captured volatility
- `o_res_price` out DATA_WIDTH: captured current price
- `o_res_warm` out 1: the stock's buffer has filled at least once
- `o_protocol_err` out 1: sticky; set when the datapath fails to respond

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, OUTPUT.
- IDLE:
  - Round-robin grant among `i_req_valid`, starting the search at `rr_ptr`.
  - `o_req_ready` is combinational, one-hot to the winner, and asserted only in IDLE.
  - On a grant: latch ask, bid and stock id k; set `rr_ptr` = k+1 mod NUM_STOCKS; go to ISSUE.
  - With no request: stay in IDLE and leave `rr_ptr` unchanged.
- ISSUE:
  - `o_dp_valid`=1.
  - `o_dp_write_address` = k*BUFFER_SIZE + `wr_ptr[k]`.
  - Increment `wr_ptr[k]` mod BUFFER_SIZE.
  - When `wr_ptr[k]` wraps from BUFFER_SIZE-1 to 0, set `warm[k]`.
  - Go to CAPTURE.
- CAPTURE:
  - `o_dp_valid`=0. `o_dp_stock_id` stays at k so the datapath's combinational volatility reflects stock k's updated sums.
  - If `i_dp_data_valid`=1: register volatility and price; set `o_res_warm` = `warm[k]` | `i_dp_buffer_full`; go to OUTPUT.
  - If `i_dp_data_valid`=0: set `o_protocol_err`, drop the sample, go to IDLE. The pointer advance is not undone.
- OUTPUT:
  - `o_res_valid`=1 with stable payload until `i_res_ready`.
  - On the handshake cycle, go to IDLE.
- `o_dp_stock_id`, `o_dp_best_ask` and `o_dp_best_bid` hold their last latched values outside ISSUE/CAPTURE.
- `o_dp_write_address` holds its last value outside ISSUE.
- Reciprocal register:
  - Loaded from `i_cfg_recip` when `i_cfg_recip_wr`=1 in IDLE; ignored in any other state.
  - The register drives `o_dp_recip` continuously.

## Timing
- Minimum request-to-result latency: accept at cycle 0, ISSUE at 1, CAPTURE at 2, `o_res_valid` at 3.
- Maximum throughput: one update per 4 cycles when `i_res_ready` is tied high.
- Reset values:
  - state IDLE
  - `rr_ptr`=0, all `wr_ptr`=0, all `warm`=0
  - `o_req_ready`=0, `o_dp_valid`=0, `o_res_valid`=0, `o_protocol_err`=0
  - all address, id, price and result outputs 0
  - reciprocal register = 2^32/BUFFER_SIZE (0x0000_0000_0800_0000 for 32)
- Reset mid-operation: immediate return to IDLE. An in-flight sample is lost, and the datapath must be reset in the same cycle.
- Simultaneous requests on all stocks: each is granted exactly once per NUM_STOCKS grants. A requester holding valid waits at most NUM_STOCKS-1 grants.
- Back-pressure: while in OUTPUT, no new grant is issued and `o_req_ready`=0.
- A `i_cfg_recip_wr` in the same IDLE cycle as a grant is applied. The granted sample uses the new value.
- `o_protocol_err` clears only on reset.

## Test plan
- Single request, stock 2, ask=102, bid=98, `i_res_ready`=1:
  - ready[2] at cycle 0
  - cycle 1: `o_dp_valid`=1, address=64, stock id=2
  - cycle 3: `o_res_valid`=1, `o_res_stock_id`=2, `o_res_price`=100
- All four stocks valid continuously: grant order is 0,1,2,3,0; each grant is spaced 4 cycles apart.
- 33 updates to stock 1:
  - addresses 32..63, then 32
  - `o_res_warm`=0 for results 1–31 and 1 from result 32 onward
- `i_res_ready`=0 for 10 cycles during OUTPUT: payload stable, `o_req_ready`=0, no `o_dp_valid`; result accepted on the cycle ready rises.
- Datapath model withholds `i_dp_data_valid` in CAPTURE: `o_protocol_err`=1, no `o_res_valid`, FSM back in IDLE; a following request is served normally.
- Reciprocal written to 0x0000_0000_1000_0000 in IDLE: `o_dp_recip` updates the next cycle. A write during ISSUE is ignored. Reset mid-ISSUE restores `wr_ptr`=0 and reciprocal 0x0800_0000.

Source files
------------

// File: rtl/volatility_sched.sv
// Round-robin scheduler sharing one volatility_mem datapath between NUM_STOCKS requesters.
// Owns per-stock circular-buffer write pointers, warm flags and the reciprocal config register.
module volatility_sched #(
    parameter int FP_WORD_SIZE = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_SIZE  = 32,
    parameter int NUM_STOCKS   = 4
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset_n,
    input  logic [NUM_STOCKS-1:0]                    i_req_valid,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]         i_req_ask,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]         i_req_bid,
    output logic [NUM_STOCKS-1:0]                    o_req_ready,
    input  logic                                     i_cfg_recip_wr,
    input  logic [FP_WORD_SIZE-1:0]                  i_cfg_recip,
    output logic                                     o_dp_valid,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_dp_write_address,
    output logic [$clog2(NUM_STOCKS)-1:0]            o_dp_stock_id,
    output logic [DATA_WIDTH-1:0]                    o_dp_best_ask,
    output logic [DATA_WIDTH-1:0]                    o_dp_best_bid,
    output logic [FP_WORD_SIZE-1:0]                  o_dp_recip,
    input  logic [FP_WORD_SIZE-1:0]                  i_dp_volatility,
    input  logic [DATA_WIDTH-1:0]                    i_dp_curr_price,
    input  logic                                     i_dp_buffer_full,
    input  logic                                     i_dp_data_valid,
    output logic                                     o_res_valid,
    input  logic                                     i_res_ready,
    output logic [$clog2(NUM_STOCKS)-1:0]            o_res_stock_id,
    output logic [FP_WORD_SIZE-1:0]                  o_res_volatility,
    output logic [DATA_WIDTH-1:0]                    o_res_price,
    output logic                                     o_res_warm,
    output logic                                     o_protocol_err
);
    localparam int SW = $clog2(NUM_STOCKS);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam logic [FP_WORD_SIZE-1:0] RECIP_RST = FP_WORD_SIZE'((64'd1 << 32) / 64'(BUFFER_SIZE));

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;

    state_t                    r_state;
    logic [SW-1:0]             r_rr_ptr;
    logic [PW-1:0]             r_wr_ptr [NUM_STOCKS];
    logic [NUM_STOCKS-1:0]     r_warm;
    logic [SW-1:0]             r_stock;
    logic [DATA_WIDTH-1:0]     r_ask;
    logic [DATA_WIDTH-1:0]     r_bid;
    logic [SW+PW-1:0]          r_addr;
    logic                      r_dp_valid;
    logic [FP_WORD_SIZE-1:0]   r_recip;
    logic                      r_res_valid;
    logic [SW-1:0]             r_res_stock;
    logic [FP_WORD_SIZE-1:0]   r_res_vol;
    logic [DATA_WIDTH-1:0]     r_res_price;
    logic                      r_res_warm;
    logic                      r_err;

    logic [NUM_STOCKS-1:0]     w_grant;
    logic [SW-1:0]             w_grant_id;
    logic [SW-1:0]             w_idx;
    logic                      w_any;

    // First valid requester at or after r_rr_ptr, wrapping modulo NUM_STOCKS.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_idx      = '0;
        w_any      = 1'b0;
        for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
            w_idx = r_rr_ptr + SW'(i);
            if (!w_any && i_req_valid[w_idx]) begin
                w_any      = 1'b1;
                w_grant_id = w_idx;
            end
        end
        w_grant[w_grant_id] = w_any;
    end

    assign o_req_ready        = (i_reset_n && r_state == IDLE) ? w_grant : '0;
    assign o_dp_valid         = r_dp_valid;
    assign o_dp_write_address = r_addr;
    assign o_dp_stock_id      = r_stock;
    assign o_dp_best_ask      = r_ask;
    assign o_dp_best_bid      = r_bid;
    assign o_dp_recip         = r_recip;
    assign o_res_valid        = r_res_valid;
    assign o_res_stock_id     = r_res_stock;
    assign o_res_volatility   = r_res_vol;
    assign o_res_price        = r_res_price;
    assign o_res_warm         = r_res_warm;
    assign o_protocol_err     = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_warm      <= '0;
            r_stock     <= '0;
            r_ask       <= '0;
            r_bid       <= '0;
            r_addr      <= '0;
            r_dp_valid  <= 1'b0;
            r_recip     <= RECIP_RST;
            r_res_valid <= 1'b0;
            r_res_stock <= '0;
            r_res_vol   <= '0;
            r_res_price <= '0;
            r_res_warm  <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < NUM_STOCKS; i++) r_wr_ptr[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cfg_recip_wr) r_recip <= i_cfg_recip;
                    if (w_any) begin
                        r_stock    <= w_grant_id;
                        r_ask      <= i_req_ask[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
                        r_bid      <= i_req_bid[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
                        // Address is registered here so it is valid throughout ISSUE.
                        r_addr     <= {w_grant_id, r_wr_ptr[w_grant_id]};
                        r_rr_ptr   <= w_grant_id + SW'(1);
                        r_dp_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_dp_valid        <= 1'b0;
                    r_wr_ptr[r_stock] <= r_wr_ptr[r_stock] + PW'(1);
                    if (r_wr_ptr[r_stock] == '1) r_warm[r_stock] <= 1'b1;
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (i_dp_data_valid) begin
                        r_res_vol   <= i_dp_volatility;
                        r_res_price <= i_dp_curr_price;
                        r_res_warm  <= r_warm[r_stock] | i_dp_buffer_full;
                        r_res_stock <= r_stock;
                        r_res_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                OUTPUT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_volatility_sched.sv
// Bench for volatility_sched: directed vector table, hand sequences and a randomized run
// against a transaction-level model, with a small combinational datapath stand-in.
module tb_volatility_sched;
    localparam int N  = 4;
    localparam int BS = 32;
    localparam int DW = 32;
    localparam int FW = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_ask, req_bid;
    logic [N-1:0]    req_ready;
    logic            cfg_wr;
    logic [FW-1:0]   cfg_recip;
    logic            dp_valid;
    logic [6:0]      dp_addr;
    logic [1:0]      dp_id;
    logic [DW-1:0]   dp_ask, dp_bid, dp_price;
    logic [FW-1:0]   dp_recip, dp_vol;
    logic            dp_bf, dp_dv;
    logic            res_valid, res_ready;
    logic [1:0]      res_id;
    logic [FW-1:0]   res_vol;
    logic [DW-1:0]   res_price;
    logic            res_warm, proto_err;

    always #5 clk = ~clk;

    volatility_sched #(.FP_WORD_SIZE(FW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(N)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .i_req_ask(req_ask), .i_req_bid(req_bid), .o_req_ready(req_ready),
        .i_cfg_recip_wr(cfg_wr), .i_cfg_recip(cfg_recip),
        .o_dp_valid(dp_valid), .o_dp_write_address(dp_addr), .o_dp_stock_id(dp_id),
        .o_dp_best_ask(dp_ask), .o_dp_best_bid(dp_bid), .o_dp_recip(dp_recip),
        .i_dp_volatility(dp_vol), .i_dp_curr_price(dp_price),
        .i_dp_buffer_full(dp_bf), .i_dp_data_valid(dp_dv),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_stock_id(res_id),
        .o_res_volatility(res_vol), .o_res_price(res_price), .o_res_warm(res_warm),
        .o_protocol_err(proto_err)
    );

    // Datapath stand-in: mid price and a volatility tagged with stock id and ask.
    assign dp_price = DW'((33'(dp_ask) + 33'(dp_bid)) >> 1);
    assign dp_vol   = {30'd0, dp_id, dp_ask};

    int checks = 0;
    int errors = 0;
    int m_rr;
    int m_cnt [N];
    bit exp_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_ask = '0; req_bid = '0;
        cfg_wr = 1'b0; cfg_recip = '0; res_ready = 1'b1; dp_dv = 1'b1; dp_bf = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_dpv",    64'(dp_valid),  64'd0);
        chk("rst_addr",   64'(dp_addr),   64'd0);
        chk("rst_id",     64'(dp_id),     64'd0);
        chk("rst_ask",    64'(dp_ask),    64'd0);
        chk("rst_resv",   64'(res_valid), 64'd0);
        chk("rst_resvol", res_vol,        64'd0);
        chk("rst_resp",   64'(res_price), 64'd0);
        chk("rst_warm",   64'(res_warm),  64'd0);
        chk("rst_err",    64'(proto_err), 64'd0);
        chk("rst_recip",  dp_recip,       64'h0000_0000_0800_0000);
        rst_n = 1'b1;
        m_rr = 0; exp_err = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One update from grant to result; entered at a negedge with the DUT idle.
    task automatic txn(input logic [N-1:0] mask, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                       input int stall, input bit dv, input bit bf,
                       input int exp_id, input int exp_addr, input bit exp_warm);
        logic [DW-1:0] ea, eb, ep;
        logic [FW-1:0] ev;
        ea = a[exp_id*DW +: DW];
        eb = b[exp_id*DW +: DW];
        ep = DW'((64'(ea) + 64'(eb)) / 2);
        ev = {32'(exp_id), ea};
        req_valid = mask; req_ask = a; req_bid = b;
        res_ready = (stall == 0); dp_dv = dv; dp_bf = bf;
        #1;
        chk("grant", 64'(req_ready), 64'd1 << exp_id);
        @(posedge clk); @(negedge clk);
        chk("issue_valid", 64'(dp_valid),  64'd1);
        chk("issue_addr",  64'(dp_addr),   64'(exp_addr));
        chk("issue_id",    64'(dp_id),     64'(exp_id));
        chk("issue_ask",   64'(dp_ask),    64'(ea));
        chk("issue_bid",   64'(dp_bid),    64'(eb));
        chk("issue_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("cap_valid", 64'(dp_valid),  64'd0);
        chk("cap_id",    64'(dp_id),     64'(exp_id));
        chk("cap_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        if (!dv) begin
            exp_err = 1'b1;
            chk("perr_flag",  64'(proto_err), 64'd1);
            chk("perr_resv",  64'(res_valid), 64'd0);
        end else begin
            chk("res_valid", 64'(res_valid), 64'd1);
            chk("res_id",    64'(res_id),    64'(exp_id));
            chk("res_price", 64'(res_price), 64'(ep));
            chk("res_vol",   res_vol,        ev);
            chk("res_warm",  64'(res_warm),  64'(exp_warm));
            chk("res_err",   64'(proto_err), 64'(exp_err));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("hold_valid", 64'(res_valid), 64'd1);
                chk("hold_price", 64'(res_price), 64'(ep));
                chk("hold_vol",   res_vol,        ev);
                chk("hold_ready", 64'(req_ready), 64'd0);
                chk("hold_dpv",   64'(dp_valid),  64'd0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            chk("res_done", 64'(res_valid), 64'd0);
        end
    endtask

    // Transaction-level reference: round-robin winner, per-stock sample counts.
    task automatic model_txn(input logic [N-1:0] mask, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                             input int stall, input bit dv, input bit bf);
        int w, addr;
        bit warm;
        w = -1;
        for (int i = 0; i < N; i++)
            if (w < 0 && mask[(m_rr + i) % N]) w = (m_rr + i) % N;
        addr = w * BS + (m_cnt[w] % BS);
        m_cnt[w]++;
        warm = (m_cnt[w] >= BS) || bf;
        m_rr = (w + 1) % N;
        txn(mask, a, b, stall, dv, bf, w, addr, warm);
    endtask

    function automatic logic [N*DW-1:0] rand_lanes();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom & 32'h7fff_ffff;
        return v;
    endfunction

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] ask;
        logic [DW-1:0] bid;
        int            stall;
        bit            dv;
        int            id;
        int            addr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0100, 32'd102,  32'd98,  0,  1'b1, 2, 64};
        tbl[1] = '{4'b1111, 32'd200,  32'd100, 0,  1'b1, 3, 96};
        tbl[2] = '{4'b1111, 32'd11,   32'd10,  0,  1'b1, 0, 0};
        tbl[3] = '{4'b1010, 32'd7,    32'd5,   0,  1'b1, 1, 32};
        tbl[4] = '{4'b0101, 32'd1000, 32'd0,   0,  1'b1, 2, 65};
        tbl[5] = '{4'b0011, 32'd50,   32'd40,  10, 1'b1, 0, 1};
        tbl[6] = '{4'b1000, 32'd9,    32'd9,   0,  1'b0, 3, 97};
        tbl[7] = '{4'b1000, 32'd30,   32'd20,  0,  1'b1, 3, 98};

        do_reset();
        foreach (tbl[i])
            txn(tbl[i].mask, {N{tbl[i].ask}}, {N{tbl[i].bid}}, tbl[i].stall, tbl[i].dv, 1'b0,
                tbl[i].id, tbl[i].addr, 1'b0);

        // All four requesting continuously: 0,1,2,3,0 at four-cycle spacing.
        do_reset();
        for (int i = 0; i < 5; i++) model_txn(4'b1111, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);

        // Buffer wrap on stock 1.
        do_reset();
        for (int i = 0; i < 33; i++) model_txn(4'b0010, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);

        // Reciprocal register and reset mid-ISSUE.
        do_reset();
        model_txn(4'b0100, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);
        model_txn(4'b0100, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);
        req_valid = '0; cfg_wr = 1'b1; cfg_recip = 64'h0000_0000_1000_0000;
        @(posedge clk); @(negedge clk);
        chk("recip_idle", dp_recip, 64'h0000_0000_1000_0000);
        req_valid = 4'b0100; cfg_recip = 64'h0000_0000_1800_0000;
        @(posedge clk); @(negedge clk);
        chk("recip_grant_dpv", 64'(dp_valid), 64'd1);
        chk("recip_grant_addr", 64'(dp_addr), 64'd66);
        chk("recip_grant", dp_recip, 64'h0000_0000_1800_0000);
        cfg_recip = 64'h0000_0000_dead_beef;
        @(posedge clk); @(negedge clk);
        chk("recip_issue_ignored", dp_recip, 64'h0000_0000_1800_0000);
        cfg_wr = 1'b0; req_valid = '0;
        @(negedge clk); @(negedge clk);
        chk("recip_txn_done", 64'(res_valid), 64'd0);
        req_valid = 4'b0100;
        @(posedge clk); @(negedge clk);
        chk("midrst_addr", 64'(dp_addr), 64'd67);
        rst_n = 1'b0; req_valid = '0;
        @(posedge clk); @(negedge clk);
        chk("midrst_recip", dp_recip, 64'h0000_0000_0800_0000);
        chk("midrst_dpv",   64'(dp_valid), 64'd0);
        chk("midrst_addr0", 64'(dp_addr),  64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1; m_rr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        model_txn(4'b1111, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);
        model_txn(4'b0100, rand_lanes(), rand_lanes(), 0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                req_valid = '0;
                #1;
                chk("idle_ready", 64'(req_ready), 64'd0);
                @(negedge clk);
            end else begin
                model_txn(N'($urandom_range(1, 15)), rand_lanes(), rand_lanes(),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 5) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
